// File: rtl/uart_tx_core_v2.sv
// Parametrised UART transmitter: LSB-first, optional parity, 1/2 stop bits.
// Define UART_TX_FIFO_EN to add a FIFO_DEPTH-word input FIFO.
module uart_tx_core_v2 #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [DIV_WIDTH-1:0]  BAUD_DIV,
  output logic                  TX_OUT,
  output logic                  Busy
);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_STOP_2
  } state_t;

  state_t                state;
  logic [DIV_WIDTH-1:0]  cnt;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_en_q;
  logic                  par_q;
  logic                  stop2_q;

  logic                  last_stop;
  logic                  free;
  logic                  load;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_par_en;
  logic                  ld_par_typ;
  logic                  ld_stop2;
  logic                  hold_busy;

  assign last_stop = (cnt == '0) &
                     (((state == S_STOP) & !stop2_q) |
                      (state == S_STOP_2));
  assign free = (state == S_IDLE) | last_stop;

`ifdef UART_TX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = DATA_WIDTH + 3;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fcnt;
  logic [AW:0]   fcnt_next;
  logic          empty;
  logic          full;
  logic          wr;
  logic          rd;

  assign empty      = (fcnt == '0);
  assign full       = (fcnt == (AW+1)'(FIFO_DEPTH));
  assign rd         = free & !empty & !RST;
  // A full FIFO still takes a word when the head leaves in the same cycle
  assign DATA_READY = !RST & (!full | rd);
  assign wr         = DATA_VALID & DATA_READY;
  assign load       = rd;
  assign {ld_stop2, ld_par_typ, ld_par_en, ld_data} = mem[rd_ptr];
  assign fcnt_next  = fcnt + (AW+1)'(wr) - (AW+1)'(rd);
  assign hold_busy  = (fcnt_next != '0);

  always_ff @(posedge CLK) begin
    if (wr)
      mem[wr_ptr] <= {STOP2, PAR_TYP, PAR_EN, P_DATA};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd)
        rd_ptr <= rd_ptr + 1'b1;
      fcnt <= fcnt_next;
    end
  end
`else
  assign DATA_READY = !RST & free;
  assign load       = DATA_VALID & DATA_READY;
  assign ld_data    = P_DATA;
  assign ld_par_en  = PAR_EN;
  assign ld_par_typ = PAR_TYP;
  assign ld_stop2   = STOP2;
  assign hold_busy  = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      div_q    <= '0;
      idx      <= '0;
      shift    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
    end else if (load) begin
      state    <= S_START;
      cnt      <= BAUD_DIV;
      div_q    <= BAUD_DIV;
      idx      <= '0;
      shift    <= ld_data;
      par_en_q <= ld_par_en;
      par_q    <= ^ld_data ^ ld_par_typ;
      stop2_q  <= ld_stop2;
      TX_OUT   <= 1'b0;
      Busy     <= 1'b1;
    end else if (free) begin
      state  <= S_IDLE;
      cnt    <= '0;
      TX_OUT <= 1'b1;
      Busy   <= hold_busy;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      cnt <= div_q;
      unique case (state)
        S_START: begin
          state  <= S_DATA;
          TX_OUT <= shift[0];
        end
        S_DATA: begin
          if (idx == LAST_BIT) begin
            state  <= par_en_q ? S_PARITY : S_STOP;
            TX_OUT <= par_en_q ? par_q : 1'b1;
          end else begin
            idx    <= idx + 1'b1;
            shift  <= shift >> 1;
            TX_OUT <= shift[1];
          end
        end
        S_PARITY: begin
          state  <= S_STOP;
          TX_OUT <= 1'b1;
        end
        // Single-stop frames end through the free path above
        S_STOP: begin
          state  <= S_STOP_2;
          TX_OUT <= 1'b1;
        end
        default: begin
          state  <= S_IDLE;
          TX_OUT <= 1'b1;
        end
      endcase
    end
  end
endmodule
